// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: folds a burst of WIDTH-bit operand pairs through a selectable bitwise op into one registered result; define LOGIC_REDUCE_PASS_EN for zero-bubble back-to-back bursts
module logic_reduce_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  logic                           in_last,
  input  logic [2:0]                     op,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_y,
  output logic                           out_bit,
  output logic [$clog2(MAX_BEATS+1)-1:0] out_count,
  output logic                           out_ovf
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] B_AND = 2'd0;
  localparam logic [1:0] B_OR  = 2'd1;
  localparam logic [1:0] B_XOR = 2'd2;

  function automatic logic [1:0] base_of(input logic [2:0] o);
    return (o == 3'd1 || o == 3'd4) ? B_OR : (o == 3'd2 || o == 3'd5) ? B_XOR : B_AND;
  endfunction

  function automatic logic [WIDTH-1:0] apply(input logic [1:0] b, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return b == B_OR ? (x | y) : b == B_XOR ? (x ^ y) : (x & y);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_bit_q, out_bit_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;
  logic             accept, start, full, done, inv;
  logic [1:0]       base;
  logic [WIDTH-1:0] ab, acc_n, y_n;
  logic [CW-1:0]    cnt_n;

`ifdef LOGIC_REDUCE_PASS_EN
  assign in_ready = !rst && (state_q != HOLD || out_ready);
`else
  assign in_ready = !rst && state_q != HOLD;
`endif
  assign out_valid = state_q == HOLD;
  assign out_y     = out_y_q;
  assign out_bit   = out_bit_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // fold the accepted beat into the accumulator and decide burst end / next state
  always_comb begin
    accept      = in_valid && in_ready;
    start       = accept && state_q != ACCUM;
    op_d        = start ? op : op_q;
    base        = base_of(op_d);
    inv         = op_d == 3'd3 || op_d == 3'd4 || op_d == 3'd5;
    ab          = apply(base, in_a, in_b);
    acc_n       = start ? ab : apply(base, acc_q, ab);
    cnt_n       = start ? CW'(1) : cnt_q + CW'(1);
    full        = cnt_n == CW'(MAX_BEATS);
    done        = accept && (in_last || full);
    y_n         = inv ? ~acc_n : acc_n;
    acc_d       = accept ? acc_n : acc_q;
    cnt_d       = accept ? cnt_n : cnt_q;
    state_d     = accept ? (done ? HOLD : ACCUM) : (state_q == HOLD && out_ready) ? IDLE : state_q;
    out_y_d     = done ? y_n : out_y_q;
    out_bit_d   = done ? (base == B_OR ? |y_n : base == B_XOR ? ^y_n : &y_n) : out_bit_q;
    out_count_d = done ? cnt_n : out_count_q;
    out_ovf_d   = done ? (full && !in_last) : out_ovf_q;
  end

  // state, burst accumulator and held result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_y_q     <= '0;
      out_bit_q   <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_y_q     <= out_y_d;
      out_bit_q   <= out_bit_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end
endmodule

// File: doc/logic_reduce_unit.md
Name: logic_reduce_unit

Overview:
Parametrised, registered successor to the team's single two-input gate.
- Applies a selectable bitwise logic op to WIDTH-bit operand pairs.
- Folds a burst of operand beats into one reduced result using a valid/ready handshake on both sides.
- Sits between a beat-streaming source and a result consumer.
- Gives the gate family real sequential behaviour: burst accumulation, backpressure and overflow detection.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- MAX_BEATS, 16, maximum beats per burst (>=1); the beat counter width is derived from it internally.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  a beat is presented.
- in_ready  output  1  the unit can accept a beat.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_last  input  1  final beat of the burst.
- op  input  3  0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; 6 and 7 decode as AND.
- out_valid  output  1  a result is held.
- out_ready  input  1  the consumer accepts the result.
- out_y  output  WIDTH  reduced result.
- out_bit  output  1  single-bit reduction of out_y.
- out_count  output  clog2(MAX_BEATS+1)  number of beats folded into the result.
- out_ovf  output  1  burst was terminated by MAX_BEATS rather than by in_last.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values: state IDLE; out_valid 0, out_y 0, out_bit 0, out_count 0, out_ovf 0, accumulator 0. in_ready is 0 while rst is high.
- Beat acceptance: a beat is accepted when in_valid && in_ready. in_ready = (state != HOLD).
- State machine (IDLE, ACCUM, HOLD):
  - IDLE: the first accepted beat latches op for the whole burst. acc = a BASE b, count = 1. Go to ACCUM, or to HOLD if this beat ends the burst.
  - ACCUM: each accepted beat does acc = acc BASE (a BASE b), count+1. Changes on op during the burst are ignored.
  - A beat ends the burst when in_last = 1 or count reaches MAX_BEATS. out_ovf = 1 only if count reached MAX_BEATS and in_last = 0.
  - HOLD: out_valid = 1. On out_valid && out_ready, go to IDLE the next cycle and drop out_valid.
- BASE operator: AND for ops 0/3, OR for ops 1/4, XOR for ops 2/5.
- Outputs on entering HOLD:
  - out_y = inverting op (3/4/5) ? ~acc : acc.
  - out_bit = &out_y, |out_y or ^out_y according to BASE, with no inversion.
  - out_count and out_ovf are registered at the same time.
- Latency: out_valid is asserted the cycle after the ending beat is accepted.
- Stability: out_y, out_bit, out_count and out_ovf are stable throughout HOLD. After the handshake they keep their values until the next burst ends.
- in_valid without acceptance, and in_valid in HOLD, have no effect. The source must hold its beat.
- rst asserted mid-burst or in HOLD discards all partial or pending results immediately.

Optional Feature:
LOGIC_REDUCE_PASS_EN
- Defined:
  - in_ready = (state != HOLD) || out_ready.
  - A beat accepted in HOLD in the same cycle as the output handshake starts a new burst (op latched, count = 1).
  - If that beat also ends its burst, the unit stays in HOLD with the new result.
  - This gives zero-bubble back-to-back bursts.
- Undefined: in_ready is 0 throughout HOLD. At least one idle cycle separates bursts.

Test Plan:
WIDTH = 8, MAX_BEATS = 4 throughout.
1. Reset: rst = 1 with in_valid = 1 -> in_ready = 0, out_valid = 0, out_y = 00, out_count = 0. Release rst -> in_ready = 1, and no result without a beat.
2. Single-beat AND: op = 0, a = F0, b = 3C, last = 1 -> next cycle out_valid = 1, out_y = 30, out_bit = 0, out_count = 1, out_ovf = 0.
3. Three-beat XNOR: op = 5, beats (FF,0F), (AA,00), (01,00); op changed to 1 on beat 2 -> acc = 5B, out_y = A4, out_bit = 1 (XOR-reduce), out_count = 3.
4. Overflow: op = 1, beats a = 01, 02, 04, 08, b = 00, last = 0 -> after beat 4, out_y = 0F, out_count = 4, out_ovf = 1. A fifth beat stalls (in_ready = 0).
5. Backpressure: hold out_ready = 0 for 5 cycles in HOLD -> out_valid and out_y stable, in_ready = 0. Raise out_ready -> out_valid = 0 the next cycle.
   - With LOGIC_REDUCE_PASS_EN, a last beat presented in the handshake cycle is accepted and its result appears one cycle later.
6. Reset mid-burst: two AND beats accepted, then a rst pulse -> no out_valid. Then NOR with a = 00, b = 00, last = 1 -> out_y = FF, out_bit = 1, out_count = 1.
